// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with ready/valid handshake, 2-entry skid buffer,
// hazard bubble injection, flush and a saturating bubble counter.
module pipe_stage_skid #(
  parameter int unsigned                DATA_W    = 96,
  parameter int unsigned                CTRL_W    = 8,
  parameter int unsigned                INSTR_W   = 32,
  parameter int unsigned                PC_W      = 32,
  parameter logic [INSTR_W-1:0]         NOP_INSTR = INSTR_W'(32'h0000_0020),
  parameter int unsigned                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               inject,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [CTRL_W-1:0]  ctrl;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  // State is the set of valid bits: main only, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               pop;
  entry_t             in_entry;

  // Ready depends only on registered state (and reset), never on out_ready.
  assign in_ready  = rst_n & (state_q != FULL);
  assign out_valid = state_q[0];
  assign out_data  = main_q.data;
  assign out_ctrl  = main_q.ctrl;
  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign occupancy = {state_q == FULL, state_q == ONE};
  assign bubble_cnt = cnt_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Incoming entry, converted to a NOP slot (keeping its PC) on inject.
  always_comb begin
    in_entry.data  = in_data;
    in_entry.ctrl  = in_ctrl;
    in_entry.instr = in_instr;
    in_entry.pc    = in_pc;
    if (inject) begin
      in_entry.data  = '0;
      in_entry.ctrl  = '0;
      in_entry.instr = NOP_INSTR;
    end
  end

  // Next-state, storage moves and bubble counting.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    if (flush) begin
      // Drop everything held; the PC on the output is left untouched.
      state_d      = EMPTY;
      main_d.data  = '0;
      main_d.ctrl  = '0;
      main_d.instr = NOP_INSTR;
      skid_d       = '{data: '0, ctrl: '0, instr: NOP_INSTR, pc: '0};
    end else begin
      if (accept && inject && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            main_d.data  = '0;
            main_d.ctrl  = '0;
            main_d.instr = NOP_INSTR;
            state_d      = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '{data: '0, ctrl: '0, instr: NOP_INSTR, pc: '0};
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and storage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '{data: '0, ctrl: '0, instr: NOP_INSTR, pc: '0};
      skid_q  <= '{data: '0, ctrl: '0, instr: NOP_INSTR, pc: '0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure,
// inject, flush, asynchronous reset mid-stream and counter saturation.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [95:0] in_data;
  logic [7:0]  in_ctrl;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        inject;
  logic        flush;
  logic        out_valid, out_valid_s;
  logic        out_ready;
  logic [95:0] out_data, out_data_s;
  logic [7:0]  out_ctrl, out_ctrl_s;
  logic [31:0] out_instr, out_instr_s;
  logic [31:0] out_pc, out_pc_s;
  logic [1:0]  occupancy, occupancy_s;
  logic [15:0] bubble_cnt;
  logic [3:0]  bubble_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_instr(in_instr), .in_pc(in_pc),
    .inject(inject), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_instr(out_instr), .out_pc(out_pc),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  pipe_stage_skid #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_instr(in_instr), .in_pc(in_pc),
    .inject(inject), .flush(flush),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_ctrl(out_ctrl_s), .out_instr(out_instr_s), .out_pc(out_pc_s),
    .occupancy(occupancy_s), .bubble_cnt(bubble_cnt_s)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [95:0] d,
                       input logic [7:0] c, input logic [31:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_data  = d;
    in_ctrl  = c;
    in_instr = ins;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; inject = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 96'h0, 8'h0, 32'h0);

    // Reset state
    #12;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_out_instr", 128'(out_instr), 128'(32'h20));
    check("rst_out_data", 128'(out_data), 128'h0);
    check("rst_out_pc", 128'(out_pc), 128'h0);
    check("rst_occ", 128'(occupancy), 128'h0);
    check("rst_cnt", 128'(bubble_cnt), 128'h0);
    check("rst_in_ready", 128'(in_ready), 128'(1'b0));
    step();
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", 128'(in_ready), 128'(1'b1));

    // Streaming, one per cycle with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 96'(i + 1), 8'(8'h10 + i), 32'(32'h1000 + i));
      check("stream_in_ready", 128'(in_ready), 128'(1'b1));
      step();
      check("stream_valid", 128'(out_valid), 128'(1'b1));
      check("stream_pc", 128'(out_pc), 128'(i * 4));
      check("stream_data", 128'(out_data), 128'(i + 1));
      check("stream_occ", 128'(occupancy), 128'h1);
    end
    drive(1'b0, 32'h0, 96'h0, 8'h0, 32'h0);
    step();
    check("drain_valid", 128'(out_valid), 128'(1'b0));
    check("drain_occ", 128'(occupancy), 128'h0);
    check("drain_pc_kept", 128'(out_pc), 128'hC);
    check("drain_instr_nop", 128'(out_instr), 128'(32'h20));
    check("drain_data_zero", 128'(out_data), 128'h0);
    check("drain_ctrl_zero", 128'(out_ctrl), 128'h0);

    // Backpressure into the skid buffer
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 96'hA, 8'h1, 32'h2000);
    step();
    check("bp_occ1", 128'(occupancy), 128'h1);
    check("bp_rdy1", 128'(in_ready), 128'(1'b1));
    drive(1'b1, 32'h14, 96'hB, 8'h2, 32'h2004);
    step();
    check("bp_occ2", 128'(occupancy), 128'h2);
    check("bp_rdy_low", 128'(in_ready), 128'(1'b0));
    check("bp_head_pc", 128'(out_pc), 128'h10);
    drive(1'b1, 32'h18, 96'hC, 8'h3, 32'h2008);
    step();
    check("bp_hold_occ", 128'(occupancy), 128'h2);
    check("bp_hold_pc", 128'(out_pc), 128'h10);
    check("bp_hold_data", 128'(out_data), 128'hA);
    out_ready = 1'b1;
    step();
    check("bp_pop1_pc", 128'(out_pc), 128'h14);
    check("bp_pop1_data", 128'(out_data), 128'hB);
    check("bp_pop1_occ", 128'(occupancy), 128'h1);
    check("bp_rdy_back", 128'(in_ready), 128'(1'b1));
    step();
    check("bp_pop2_pc", 128'(out_pc), 128'h18);
    check("bp_pop2_data", 128'(out_data), 128'hC);
    check("bp_pop2_occ", 128'(occupancy), 128'h1);
    drive(1'b0, 32'h0, 96'h0, 8'h0, 32'h0);
    step();
    check("bp_empty_valid", 128'(out_valid), 128'(1'b0));
    check("bp_empty_occ", 128'(occupancy), 128'h0);

    // Bubble injection
    out_ready = 1'b0;
    inject = 1'b1;
    drive(1'b1, 32'h40, 96'h1234_5678, 8'hFF, 32'h8C22_0004);
    step();
    check("inj_valid", 128'(out_valid), 128'(1'b1));
    check("inj_ctrl", 128'(out_ctrl), 128'h0);
    check("inj_data", 128'(out_data), 128'h0);
    check("inj_instr", 128'(out_instr), 128'(32'h20));
    check("inj_pc", 128'(out_pc), 128'h40);
    check("inj_cnt", 128'(bubble_cnt), 128'h1);

    // Fill to FULL, then flush with valid+inject
    inject = 1'b0;
    drive(1'b1, 32'h44, 96'h44, 8'h4, 32'h3000);
    step();
    check("fl_full_occ", 128'(occupancy), 128'h2);
    flush = 1'b1; inject = 1'b1;
    drive(1'b1, 32'h48, 96'h48, 8'h5, 32'h3004);
    step();
    check("fl_occ", 128'(occupancy), 128'h0);
    check("fl_valid", 128'(out_valid), 128'(1'b0));
    check("fl_pc_kept", 128'(out_pc), 128'h40);
    check("fl_cnt", 128'(bubble_cnt), 128'h1);
    check("fl_instr", 128'(out_instr), 128'(32'h20));
    // Flush while empty drops a real acceptance with inject
    check("fl2_rdy", 128'(in_ready), 128'(1'b1));
    step();
    check("fl2_occ", 128'(occupancy), 128'h0);
    check("fl2_cnt", 128'(bubble_cnt), 128'h1);
    check("fl2_pc_kept", 128'(out_pc), 128'h40);
    flush = 1'b0; inject = 1'b0;

    // Asynchronous reset with two entries held
    drive(1'b1, 32'h50, 96'h50, 8'h6, 32'h4000);
    step();
    drive(1'b1, 32'h54, 96'h54, 8'h7, 32'h4004);
    step();
    check("ar_pre_occ", 128'(occupancy), 128'h2);
    drive(1'b0, 32'h0, 96'h0, 8'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 128'(out_valid), 128'(1'b0));
    check("ar_instr", 128'(out_instr), 128'(32'h20));
    check("ar_occ", 128'(occupancy), 128'h0);
    check("ar_cnt", 128'(bubble_cnt), 128'h0);
    check("ar_in_ready", 128'(in_ready), 128'(1'b0));
    check("ar_pc", 128'(out_pc), 128'h0);
    step();
    rst_n = 1'b1;

    // Counter saturation: 20 injected bubbles while streaming
    out_ready = 1'b1;
    inject = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(32'h100 + i * 4), 96'hFFFF, 8'hAA, 32'h5000);
      step();
      if (i == 13) begin
        check("sat_mid_small", 128'(bubble_cnt_s), 128'hE);
      end
    end
    check("sat_small", 128'(bubble_cnt_s), 128'hF);
    check("sat_wide", 128'(bubble_cnt), 128'd20);
    check("sat_instr", 128'(out_instr), 128'(32'h20));
    check("sat_pc", 128'(out_pc), 128'h14C);
    inject = 1'b0;
    drive(1'b0, 32'h0, 96'h0, 8'h0, 32'h0);
    step();
    check("sat_hold", 128'(bubble_cnt_s), 128'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
